// File: rtl/avmm_txn_tracker.sv
// avmm_txn_tracker
// Pipeline and transaction-tracking stage between the HPS address remapper
// (s_* side) and the R-tile usrhip Avalon-MM slave (m_* side).
//  - One-entry command register, issued to the HIP when the in-flight limit
//    (outstanding + pending drops) allows.
//  - In-order type FIFO (1 = read) so every completion, real or synthetic,
//    retires the oldest transaction.
//  - Down-counting watchdog: when no completion is seen for TIMEOUT_CYCLES
//    cycles, a synthetic error response is returned for the oldest entry and
//    its eventual real response is later discarded (drop_cnt).
// Ports:
//  clk, rst                     clock, synchronous active-high reset
//  s_*                          command in / response out (remapper side)
//  m_*                          command out / response in (HIP side)
//  outstanding_o                in-flight transaction count
//  timeout_count_o              saturating count of synthetic responses
module avmm_txn_tracker #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    RESP_WIDTH      = 2,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter int                    TIMEOUT_CYCLES  = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA    = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_address,
  input  logic [DATA_WIDTH-1:0]   s_writedata,
  input  logic [DATA_WIDTH/8-1:0] s_byteenable,
  input  logic                    s_read,
  input  logic                    s_write,
  input  logic                    s_burstcount,
  input  logic                    s_debugaccess,
  output logic                    s_waitrequest,
  output logic [DATA_WIDTH-1:0]   s_readdata,
  output logic                    s_readdatavalid,
  output logic                    s_writerespvalid,
  output logic [RESP_WIDTH-1:0]   s_resp,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic [DATA_WIDTH-1:0]   m_writedata,
  output logic [DATA_WIDTH/8-1:0] m_byteenable,
  output logic                    m_read,
  output logic                    m_write,
  output logic                    m_burstcount,
  output logic                    m_debugaccess,
  input  logic                    m_waitrequest,
  input  logic                    m_readdatavalid,
  input  logic                    m_writerespvalid,
  input  logic [DATA_WIDTH-1:0]   m_readdata,
  input  logic [RESP_WIDTH-1:0]   m_resp,
  output logic [4:0]              outstanding_o,
  output logic [15:0]             timeout_count_o
);

  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BEW = DATA_WIDTH / 8;

  logic                       cmd_valid_q, cmd_valid_d;
  logic                       cmd_rd_q, cmd_rd_d;
  logic [ADDR_WIDTH-1:0]      cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0]      cmd_wdata_q, cmd_wdata_d;
  logic [BEW-1:0]             cmd_be_q, cmd_be_d;
  logic                       cmd_burst_q, cmd_burst_d;
  logic                       cmd_dbg_q, cmd_dbg_d;

  logic [MAX_OUTSTANDING-1:0] type_q, type_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [4:0]                 outst_q, outst_d;
  logic [4:0]                 drop_q, drop_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [15:0]                tocnt_q, tocnt_d;

  logic                       rdv_q, rdv_d;
  logic                       wrv_q, wrv_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0]      resp_q, resp_d;

  logic [5:0] inflight;
  logic       can_issue, issue, accept;
  logic       real_rsp, real_cpl, late, fire, cpl, head_rd;

  // Pending drops still occupy HIP slots, so they count against the limit.
  assign inflight  = {1'b0, outst_q} + {1'b0, drop_q};
  assign can_issue = (inflight < 6'(MAX_OUTSTANDING));
  assign issue     = cmd_valid_q & ~m_waitrequest & can_issue;
  assign s_waitrequest = rst | (cmd_valid_q & ~issue);
  assign accept    = (s_read | s_write) & ~s_waitrequest;

  assign real_rsp  = m_readdatavalid | m_writerespvalid;
  assign real_cpl  = real_rsp & (drop_q == 5'd0) & (outst_q != 5'd0);
  assign late      = real_rsp & (drop_q != 5'd0);
  // Any real response that cycle (even a late one) defers the fire, which
  // also keeps fire and late mutually exclusive for drop_cnt.
  assign fire      = (outst_q != 5'd0) & (timer_q == '0) & ~real_rsp;
  assign cpl       = real_cpl | fire;
  assign head_rd   = type_q[rd_ptr_q];

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_rd_d    = cmd_rd_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_be_d    = cmd_be_q;
    cmd_burst_d = cmd_burst_q;
    cmd_dbg_d   = cmd_dbg_q;
    if (issue) cmd_valid_d = 1'b0;
    if (accept) begin
      cmd_valid_d = 1'b1;
      cmd_rd_d    = s_read;
      cmd_addr_d  = s_address;
      cmd_wdata_d = s_writedata;
      cmd_be_d    = s_byteenable;
      cmd_burst_d = s_burstcount;
      cmd_dbg_d   = s_debugaccess;
    end

    type_d   = type_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (issue) begin
      type_d[wr_ptr_q] = cmd_rd_q;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (cpl) rd_ptr_d = rd_ptr_q + 1'b1;

    outst_d = outst_q + {4'd0, issue} - {4'd0, cpl};
    drop_d  = drop_q + {4'd0, fire} - {4'd0, late};
    tocnt_d = (fire && (tocnt_q != 16'hFFFF)) ? tocnt_q + 16'd1 : tocnt_q;

    // Reload on any completion or when idle; hold at terminal count while a
    // late response defers the fire.
    if ((outst_q == 5'd0) || cpl)  timer_d = TW'(TIMEOUT_CYCLES - 1);
    else if (timer_q != '0)        timer_d = timer_q - 1'b1;
    else                           timer_d = timer_q;

    rdv_d   = 1'b0;
    wrv_d   = 1'b0;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    if (real_cpl) begin
      rdv_d   = m_readdatavalid;
      wrv_d   = m_writerespvalid;
      rdata_d = m_readdata;
      resp_d  = m_resp;
    end else if (fire) begin
      rdv_d   = head_rd;
      wrv_d   = ~head_rd;
      rdata_d = head_rd ? TIMEOUT_DATA : rdata_q;
      resp_d  = RESP_WIDTH'(2'b10);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_rd_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
      cmd_burst_q <= 1'b0;
      cmd_dbg_q   <= 1'b0;
      type_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      outst_q     <= '0;
      drop_q      <= '0;
      timer_q     <= TW'(TIMEOUT_CYCLES - 1);
      tocnt_q     <= '0;
      rdv_q       <= 1'b0;
      wrv_q       <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_be_q    <= cmd_be_d;
      cmd_burst_q <= cmd_burst_d;
      cmd_dbg_q   <= cmd_dbg_d;
      type_q      <= type_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      timer_q     <= timer_d;
      tocnt_q     <= tocnt_d;
      rdv_q       <= rdv_d;
      wrv_q       <= wrv_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  assign m_address     = cmd_addr_q;
  assign m_writedata   = cmd_wdata_q;
  assign m_byteenable  = cmd_be_q;
  assign m_burstcount  = cmd_burst_q;
  assign m_debugaccess = cmd_dbg_q;
  // Strobes stay up through m_waitrequest: the command register only
  // changes on issue, and the limit check cannot drop while waiting.
  assign m_read        = cmd_valid_q & cmd_rd_q & can_issue;
  assign m_write       = cmd_valid_q & ~cmd_rd_q & can_issue;

  assign s_readdatavalid  = rdv_q;
  assign s_writerespvalid = wrv_q;
  assign s_readdata       = rdata_q;
  assign s_resp           = resp_q;
  assign outstanding_o    = outst_q;
  assign timeout_count_o  = tocnt_q;

endmodule

// File: tb/tb_avmm_txn_tracker.sv
// Bench for avmm_txn_tracker (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=16).
// Expected s_* responses are queued when the HIP response (or an expected
// timeout) is driven; a negedge monitor pops and compares them.
module tb_avmm_txn_tracker;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int TC = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   s_address = '0;
  logic [DW-1:0]   s_writedata = '0;
  logic [DW/8-1:0] s_byteenable = '0;
  logic            s_read = 1'b0;
  logic            s_write = 1'b0;
  logic            s_burstcount = 1'b1;
  logic            s_debugaccess = 1'b0;
  logic            s_waitrequest;
  logic [DW-1:0]   s_readdata;
  logic            s_readdatavalid;
  logic            s_writerespvalid;
  logic [1:0]      s_resp;
  logic [AW-1:0]   m_address;
  logic [DW-1:0]   m_writedata;
  logic [DW/8-1:0] m_byteenable;
  logic            m_read;
  logic            m_write;
  logic            m_burstcount;
  logic            m_debugaccess;
  logic            m_waitrequest = 1'b0;
  logic            m_readdatavalid = 1'b0;
  logic            m_writerespvalid = 1'b0;
  logic [DW-1:0]   m_readdata = '0;
  logic [1:0]      m_resp = '0;
  logic [4:0]      outstanding_o;
  logic [15:0]     timeout_count_o;

  always #5 clk = ~clk;

  avmm_txn_tracker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(2),
    .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TC), .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write), .s_burstcount(s_burstcount),
    .s_debugaccess(s_debugaccess), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_writerespvalid(s_writerespvalid), .s_resp(s_resp),
    .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_burstcount(m_burstcount),
    .m_debugaccess(m_debugaccess), .m_waitrequest(m_waitrequest),
    .m_readdatavalid(m_readdatavalid), .m_writerespvalid(m_writerespvalid),
    .m_readdata(m_readdata), .m_resp(m_resp),
    .outstanding_o(outstanding_o), .timeout_count_o(timeout_count_o)
  );

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a command and hold it until accepted; returns at the negedge
  // after the accepting edge with the command strobes dropped.
  task automatic send(input bit rd, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    n = 0;
    s_read       = rd;
    s_write      = ~rd;
    s_address    = addr;
    s_writedata  = wd;
    s_byteenable = 4'hF;
    #1;
    while (s_waitrequest && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_bound", 64'(n < 50), 64'd1);
    @(negedge clk);
    s_read  = 1'b0;
    s_write = 1'b0;
  endtask

  // One-cycle HIP response; queue the expected forward when it should reach s_*.
  task automatic hip(input bit rd, input logic [31:0] d, input logic [1:0] r, input bit fwd);
    if (fwd) sb.push_back('{rd: rd, data: d, resp: r});
    m_readdatavalid  = rd;
    m_writerespvalid = ~rd;
    m_readdata       = d;
    m_resp           = r;
    @(negedge clk);
    m_readdatavalid  = 1'b0;
    m_writerespvalid = 1'b0;
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(s_readdatavalid || s_writerespvalid) && k < 60);
  endtask

  always @(negedge clk) begin
    if (s_readdatavalid || s_writerespvalid) begin
      if (sb.size() == 0) begin
        chk("unexp_rsp", 64'({s_readdatavalid, s_writerespvalid}), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_strobe", 64'({s_readdatavalid, s_writerespvalid}), 64'({mon_e.rd, ~mon_e.rd}));
        chk("rsp_code", 64'(s_resp), 64'(mon_e.resp));
        if (mon_e.rd) chk("rsp_data", 64'(s_readdata), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_wait", 64'(s_waitrequest), 64'd1);
    chk("rst_strobes", 64'({s_readdatavalid, s_writerespvalid, m_read, m_write}), 64'd0);
    chk("rst_outst", 64'(outstanding_o), 64'd0);
    chk("rst_tocnt", 64'(timeout_count_o), 64'd0);
    rst = 1'b0;
    #1 chk("rst_rel_wait", 64'(s_waitrequest), 64'd0);
    @(negedge clk);

    // single read, HIP answers three cycles after issue
    send(1'b1, 32'h100, 32'h0);
    chk("rd_mread", 64'({m_read, m_write}), 64'b10);
    chk("rd_maddr", 64'(m_address), 64'h100);
    @(negedge clk);
    chk("rd_issued", 64'({m_read, outstanding_o}), 64'({1'b0, 5'd1}));
    @(negedge clk);
    @(negedge clk);
    hip(1'b1, 32'h1234_5678, 2'b00, 1'b1);
    chk("rd_lat", 64'(s_readdatavalid), 64'd1);
    chk("rd_outst", 64'(outstanding_o), 64'd0);

    // outstanding limit: 4 issue, 5th held
    for (int i = 0; i < 5; i++) send(1'b1, 32'h1000 + 32'(i * 4), 32'h0);
    chk("lim_outst", 64'(outstanding_o), 64'd4);
    chk("lim_mread", 64'(m_read), 64'd0);
    chk("lim_wait", 64'(s_waitrequest), 64'd1);
    hip(1'b1, 32'hD000_0001, 2'b00, 1'b1);
    chk("lim_issue", 64'({m_read, m_address}), 64'({1'b1, 32'h1010}));
    @(negedge clk);
    chk("lim_outst2", 64'(outstanding_o), 64'd4);
    for (int i = 0; i < 4; i++) hip(1'b1, 32'hD000_0002 + 32'(i), 2'(i), 1'b1);
    chk("lim_drain", 64'(outstanding_o), 64'd0);

    // write timeout, then late HIP response dropped
    send(1'b0, 32'h2000, 32'h55);
    sb.push_back('{rd: 1'b0, data: 32'h0, resp: 2'b10});
    wait_rsp(k);
    chk("wto_lat", 64'(k), 64'd17);
    chk("wto_cnt", 64'(timeout_count_o), 64'd1);
    chk("wto_outst", 64'(outstanding_o), 64'd0);
    hip(1'b0, 32'h0, 2'b00, 1'b0);
    chk("wto_late_drop", 64'({s_readdatavalid, s_writerespvalid}), 64'd0);

    // read timeout, then next read forwarded after the late one is dropped
    send(1'b1, 32'h3000, 32'h0);
    sb.push_back('{rd: 1'b1, data: 32'hDEAD_BEEF, resp: 2'b10});
    wait_rsp(k);
    chk("rto_lat", 64'(k), 64'd17);
    chk("rto_data", 64'(s_readdata), 64'hDEAD_BEEF);
    chk("rto_cnt", 64'(timeout_count_o), 64'd2);
    send(1'b1, 32'h3004, 32'h0);
    hip(1'b1, 32'h0BAD_0BAD, 2'b00, 1'b0);
    chk("rto_late_drop", 64'(s_readdatavalid), 64'd0);
    hip(1'b1, 32'hCAFE_0002, 2'b00, 1'b1);
    chk("rto_next", 64'(s_readdatavalid), 64'd1);
    chk("rto_outst", 64'(outstanding_o), 64'd0);

    // backpressure: command held stable, second command waits for issue
    m_waitrequest = 1'b1;
    send(1'b0, 32'h200, 32'hA5A5_5A5A);
    s_write     = 1'b1;
    s_address   = 32'h204;
    s_writedata = 32'h0F0F_F0F0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_hold", 64'({m_write, m_read, s_waitrequest, (m_address == 32'h200),
                          (m_writedata == 32'hA5A5_5A5A)}), 64'b10111);
      @(negedge clk);
    end
    m_waitrequest = 1'b0;
    #1 chk("bp_rel_wait", 64'(s_waitrequest), 64'd0);
    @(negedge clk);
    s_write = 1'b0;
    chk("bp_second", 64'({m_write, m_address, m_writedata}), 64'({1'b1, 32'h204, 32'h0F0F_F0F0}));
    chk("bp_outst1", 64'(outstanding_o), 64'd1);
    @(negedge clk);
    chk("bp_outst2", 64'(outstanding_o), 64'd2);
    hip(1'b0, 32'h0, 2'b00, 1'b1);
    hip(1'b0, 32'h0, 2'b01, 1'b1);
    chk("bp_drain", 64'(outstanding_o), 64'd0);

    // reset with three in flight; later HIP responses are spurious
    for (int i = 0; i < 3; i++) send(1'b1, 32'h400 + 32'(i * 4), 32'h0);
    @(negedge clk);
    chk("mrst_pre", 64'(outstanding_o), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_outst", 64'(outstanding_o), 64'd0);
    chk("mrst_wait", 64'(s_waitrequest), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) hip(1'b1, 32'h7700 + 32'(i), 2'b00, 1'b0);
    repeat (20) @(negedge clk);
    chk("mrst_post_outst", 64'(outstanding_o), 64'd0);
    chk("mrst_tocnt", 64'(timeout_count_o), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
